// File: rtl/desc_mem_pkg.sv
// rtl/desc_mem_pkg.sv - shared types and widths for the descriptor RAM arbiter
package desc_mem_pkg;

  localparam int DESC_ADDR_W = 11;
  localparam int DESC_DATA_W = 32;
  localparam int DESC_BE_W   = 4;

  typedef enum logic {
    LK_IDLE,
    LK_LOCKED
  } lock_state_t;

  typedef logic master_id_t;

endpackage

// File: rtl/descriptor_memory_arbiter.sv
// rtl/descriptor_memory_arbiter.sv - round-robin two-master arbiter with RMW lock for one descriptor RAM port
module descriptor_memory_arbiter
  import desc_mem_pkg::*;
#(
  parameter int ADDR_W       = DESC_ADDR_W,
  parameter int DATA_W       = DESC_DATA_W,
  parameter int BE_W         = DESC_BE_W,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              lock_timeout_err
);

  localparam int             CNT_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  lock_state_t      lock_state_q, lock_state_d;
  master_id_t       owner_q, owner_d;
  master_id_t       rr_last_q, rr_last_d;
  master_id_t       rd_id_q, rd_id_d;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       accept;
  master_id_t gnt_id;
  logic       sel_write, sel_lock;
  logic       owner_req;
  logic       timeout;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // rr_last_q names the most recent winner, so the other master wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (lock_state_q == LK_LOCKED) begin
        gnt0 = req0 & (owner_q == 1'b0);
        gnt1 = req1 & (owner_q == 1'b1);
      end else if (req0 && req1) begin
        gnt0 = rr_last_q;
        gnt1 = ~rr_last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign accept    = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign sel_write = gnt1 ? m1_write : m0_write;
  assign sel_lock  = gnt1 ? m1_lock  : m0_lock;

  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = accept;
  assign mem_write      = accept & sel_write;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Read data bus is shared; only the valid strobe is steered by rd_id
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = ~reset & rd_pend_q & (rd_id_q == 1'b0);
  assign m1_readdatavalid = ~reset & rd_pend_q & (rd_id_q == 1'b1);

  assign owner_req = owner_q ? req1 : req0;
  assign timeout   = ~reset & (lock_state_q == LK_LOCKED) & ~owner_req &
                     (idle_cnt_q == CNT_LAST);
  assign lock_timeout_err = timeout;

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    idle_cnt_d   = idle_cnt_q;
    rd_pend_d    = accept & ~sel_write;
    rd_id_d      = accept ? gnt_id : rd_id_q;

    if (accept) begin
      rr_last_d = gnt_id;
    end

    case (lock_state_q)
      LK_IDLE: begin
        idle_cnt_d = '0;
        if (accept && sel_lock) begin
          lock_state_d = LK_LOCKED;
          owner_d      = gnt_id;
        end
      end
      LK_LOCKED: begin
        if (owner_req) begin
          idle_cnt_d = '0;
          if (accept && !sel_lock) begin
            lock_state_d = LK_IDLE;
          end
        end else if (timeout) begin
          // Forced release hands priority away from the stalled owner
          lock_state_d = LK_IDLE;
          idle_cnt_d   = '0;
          rr_last_d    = owner_q;
        end else if (idle_cnt_q != CNT_MAX) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        lock_state_d = LK_IDLE;
        idle_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_q <= LK_IDLE;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;
      rd_id_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      rd_id_q      <= rd_id_d;
      rd_pend_q    <= rd_pend_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_descriptor_memory_arbiter.sv
// tb/tb_descriptor_memory_arbiter.sv - randomized scoreboard bench for descriptor_memory_arbiter
module tb_descriptor_memory_arbiter;
  import desc_mem_pkg::*;

  localparam int LT = 64;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          lk;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    int id;
    int cyc;
  } gnt_rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [10:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken, lock_timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cmd_t     q0[$];
  cmd_t     q1[$];
  cmd_t     cur[2];
  bit       cur_v[2];
  bit       acc[2];
  rd_exp_t  sb[$];
  gnt_rec_t gl[$];

  logic [31:0] ram[0:2047];
  logic [31:0] golden[0:2047];
  logic [10:0] ram_addr_q;

  int lk_owner = -1;
  int last = 1;
  int idle = 0;
  int blk1 = 0;
  int errc = 0;
  int err_cyc = 0;

  assign m0_read       = cur_v[0] & cur[0].rd;
  assign m0_write      = cur_v[0] & cur[0].wr;
  assign m0_lock       = cur_v[0] & cur[0].lk;
  assign m0_address    = cur[0].addr;
  assign m0_byteenable = cur[0].be;
  assign m0_writedata  = cur[0].data;
  assign m1_read       = cur_v[1] & cur[1].rd;
  assign m1_write      = cur_v[1] & cur[1].wr;
  assign m1_lock       = cur_v[1] & cur[1].lk;
  assign m1_address    = cur[1].addr;
  assign m1_byteenable = cur[1].be;
  assign m1_writedata  = cur[1].data;

  descriptor_memory_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .lock_timeout_err(lock_timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM port: registered address, unregistered q
  always @(posedge clk) begin
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic cmd_t mk(input bit rd, input bit wr, input bit lk, input int addr,
                              input int be, input logic [31:0] data);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.lk = lk;
    c.addr = addr[10:0]; c.be = be[3:0]; c.data = data;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic need_grants(input string name, input int n);
    n_checks++;
    if (gl.size() < n) begin
      n_errors++;
      $display("FAIL %s: got %0d grants expected at least %0d", name, gl.size(), n);
    end
  endtask

  task automatic chk_gnt(input string name, input int k, input int id);
    if (gl.size() > k) check(name, gl[k].id, id);
  endtask

  // Master drivers: hold each command until the arbiter accepts it
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (cur_v[i] && (acc[i] || !(cur[i].rd || cur[i].wr))) cur_v[i] = 1'b0;
      if (!cur_v[i]) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          cur_v[0] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          cur_v[1] = 1'b1;
        end
      end
    end
  end

  // Reference model: arbitration rules, lock ownership and a golden memory image
  always @(negedge clk) begin
    bit          rq[2];
    bit          wq[2];
    bit          lq[2];
    logic [10:0] a[2];
    logic [3:0]  b[2];
    logic [31:0] d[2];
    int          g;
    bit          to;
    rq[0] = m0_read | m0_write;  rq[1] = m1_read | m1_write;
    wq[0] = m0_write;            wq[1] = m1_write;
    lq[0] = m0_lock;             lq[1] = m1_lock;
    a[0] = m0_address;           a[1] = m1_address;
    b[0] = m0_byteenable;        b[1] = m1_byteenable;
    d[0] = m0_writedata;         d[1] = m1_writedata;

    acc[0] = rq[0] && !m0_waitrequest && !reset;
    acc[1] = rq[1] && !m1_waitrequest && !reset;
    if (acc[0]) gl.push_back('{id: 0, cyc: cyc});
    if (acc[1]) gl.push_back('{id: 1, cyc: cyc});
    if (lock_timeout_err) begin
      errc++;
      err_cyc = cyc;
    end
    if (rq[1] && m1_waitrequest && !reset) blk1++;

    g = -1;
    if (!reset) begin
      if (lk_owner >= 0) g = rq[lk_owner] ? lk_owner : -1;
      else if (rq[0] && rq[1]) g = 1 - last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end
    to = !reset && lk_owner >= 0 && !rq[lk_owner] && (idle + 1 == LT);

    check("m0_waitrequest", m0_waitrequest, g != 0);
    check("m1_waitrequest", m1_waitrequest, g != 1);
    check("mem_chipselect", mem_chipselect, g >= 0);
    check("mem_write", mem_write, g >= 0 && wq[g]);
    check("lock_timeout_err", lock_timeout_err, to);
    if (g >= 0) begin
      check("mem_address", mem_address, a[g]);
      check("mem_byteenable", mem_byteenable, b[g]);
      if (wq[g]) check("mem_writedata", mem_writedata, d[g]);
    end

    if (reset) begin
      lk_owner = -1;
      last = 1;
      idle = 0;
    end else if (g >= 0) begin
      last = g;
      if (wq[g]) golden[a[g]] = merge(golden[a[g]], d[g], b[g]);
      else sb.push_back('{id: g, data: golden[a[g]], due: cyc + 1});
      if (lk_owner < 0) begin
        if (lq[g]) lk_owner = g;
      end else if (!lq[g]) begin
        lk_owner = -1;
      end
      idle = 0;
    end else if (lk_owner >= 0) begin
      if (to) begin
        last = lk_owner;
        lk_owner = -1;
        idle = 0;
      end else begin
        idle++;
      end
    end
  end

  // Read-return monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (reset) begin
      check("readdatavalid_in_reset", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      sb.delete();
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("m0_readdatavalid", m0_readdatavalid, e.id == 0);
      check("m1_readdatavalid", m1_readdatavalid, e.id == 1);
      check("readdata", (e.id == 0) ? m0_readdata : m1_readdata, e.data);
    end else begin
      check("spurious_readdatavalid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    end
  end

  task automatic wait_idle(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cur_v[0] || cur_v[1]) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: got %0d cycles without draining, limit %0d", n, max);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int n;
    for (int i = 0; i < 2048; i++) begin
      v = $urandom;
      ram[i] <= v;
      golden[i] = v;
    end
    ram[16] <= 32'hA5A5_0001;
    golden[16] = 32'hA5A5_0001;

    // contention straight out of reset: m0 first, then strict alternation
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(0, 1, 0, 'h100 + k, 'hF, $urandom));
      q1.push_back(mk(0, 1, 0, 'h140 + k, 'hF, $urandom));
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_idle(100);
    need_grants("contention_grants", 8);
    for (int k = 0; k < 8; k++) chk_gnt("contention_order", k, k % 2);
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1, 0, 0, 'h100 + k, 0, 0));
      q0.push_back(mk(1, 0, 0, 'h140 + k, 0, 0));
    end
    wait_idle(100);

    // single uncontended read of a preloaded word
    gl.delete();
    q0.push_back(mk(1, 0, 0, 'h010, 'hF, 0));
    wait_idle(50);
    need_grants("single_grants", 1);
    chk_gnt("single_grant_id", 0, 0);

    // locked read-modify-write by m1 while m0 requests every cycle
    gl.delete();
    q1.push_back(mk(1, 0, 1, 'h020, 'hF, 0));
    q1.push_back(mk(0, 1, 0, 'h020, 'h1, $urandom));
    for (int k = 0; k < 4; k++) q0.push_back(mk(0, 1, 0, 'h030 + k, 'hF, $urandom));
    wait_idle(100);
    need_grants("rmw_grants", 6);
    chk_gnt("rmw_read", 0, 1);
    chk_gnt("rmw_write", 1, 1);
    chk_gnt("rmw_m0_next", 2, 0);
    if (gl.size() >= 3) begin
      check("rmw_back_to_back", gl[1].cyc - gl[0].cyc, 1);
      check("rmw_m0_after_unlock", gl[2].cyc - gl[1].cyc, 1);
    end
    q0.push_back(mk(1, 0, 0, 'h020, 0, 0));
    wait_idle(50);

    // lock timeout: owner goes silent, m1 waits out the full window
    gl.delete();
    blk1 = 0;
    errc = 0;
    q0.push_back(mk(0, 1, 1, 'h040, 'hF, $urandom));
    q1.push_back(mk(0, 0, 0, 0, 0, 0));
    q1.push_back(mk(1, 0, 0, 'h041, 'hF, 0));
    q1.push_back(mk(1, 0, 0, 'h040, 'hF, 0));
    wait_idle(300);
    need_grants("timeout_grants", 3);
    chk_gnt("timeout_lock_owner", 0, 0);
    chk_gnt("timeout_m1_grant", 1, 1);
    check("timeout_blocked_cycles", blk1, LT);
    check("timeout_err_pulses", errc, 1);
    if (gl.size() >= 2) begin
      check("timeout_grant_after_pulse", gl[1].cyc, err_cyc + 1);
      check("timeout_latency", gl[1].cyc - gl[0].cyc, LT + 1);
    end

    // reset while m1 holds a lock, then simultaneous requests
    q1.push_back(mk(0, 1, 1, 'h050, 'hF, $urandom));
    wait_idle(50);
    repeat (3) @(negedge clk);
    pulse_reset();
    gl.delete();
    q0.push_back(mk(0, 1, 0, 'h051, 'hF, $urandom));
    q1.push_back(mk(0, 1, 0, 'h052, 'hF, $urandom));
    wait_idle(50);
    need_grants("post_reset_grants", 2);
    chk_gnt("post_reset_first", 0, 0);
    chk_gnt("post_reset_second", 1, 1);

    // reset the cycle after an accepted locked read: data and lock both dropped
    q0.push_back(mk(1, 0, 1, 'h010, 'hF, 0));
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!acc[0] && n < 20);
    check("reset_read_accepted", acc[0], 1'b1);
    pulse_reset();
    gl.delete();
    q1.push_back(mk(0, 1, 0, 'h053, 'hF, $urandom));
    wait_idle(50);
    need_grants("lock_dropped_grants", 1);
    chk_gnt("lock_dropped_m1", 0, 1);

    // back-to-back reads, uncontended
    gl.delete();
    for (int k = 0; k < 4; k++) q0.push_back(mk(1, 0, 0, k, 'hF, 0));
    wait_idle(50);
    need_grants("b2b_grants", 4);
    if (gl.size() >= 4)
      for (int k = 1; k < 4; k++) check("b2b_consecutive", gl[k].cyc - gl[k-1].cyc, 1);

    // randomized mixed traffic with occasional locks on a small address window
    for (int k = 0; k < 150; k++) begin
      for (int m = 0; m < 2; m++) begin
        int r;
        cmd_t c;
        r = $urandom_range(0, 5);
        if (r == 0) c = mk(0, 0, 0, 0, 0, 0);
        else c = mk(r < 3, r >= 3, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom);
        if (m == 0) q0.push_back(c);
        else q1.push_back(c);
      end
    end
    q0.push_back(mk(0, 1, 0, 'h3FF, 'hF, $urandom));
    q1.push_back(mk(0, 1, 0, 'h3FE, 'hF, $urandom));
    wait_idle(5000);
    for (int k = 0; k < 16; k++) q1.push_back(mk(1, 0, 0, k, 'hF, 0));
    wait_idle(100);

    check("outstanding_reads", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/descriptor_memory_arbiter.md
Name: descriptor_memory_arbiter

Overview:
- Shares one Avalon-MM port of the Ethernet subsystem's 2048x32 dual-port descriptor RAM between two requesters: m0 (TX descriptor engine) and m1 (RX descriptor engine).
- Arbitration is round-robin. A lock lets one master run an uninterrupted read-modify-write of descriptor ownership/status words.
- Read data is returned with readdatavalid, using the RAM's fixed one-cycle read latency (registered address, unregistered q).

Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- LOCK_TIMEOUT, 64, owner-idle cycles before a held lock is forcibly released

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  hold grant after this transfer
- m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid
- mem_address  out  ADDR_W  to RAM port
- mem_byteenable  out  BE_W  to RAM port
- mem_chipselect  out  1  to RAM port
- mem_write  out  1  to RAM port
- mem_writedata  out  DATA_W  to RAM port
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  RAM q, valid one cycle after the address cycle
- lock_timeout_err  out  1  one-cycle pulse on forced lock release

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous, active-high, on port reset.
- Request definition: reqN = mN_read | mN_write. A request with both read and write set is illegal; write wins and the read is ignored.
- Grant (combinational, same cycle):
  - If a lock is active, only the lock owner can be granted.
  - Otherwise, if only one master requests, it is granted.
  - If both request, the master not granted most recently wins (rr_last register).
- Acceptance:
  - The granted master sees waitrequest=0; its command drives the mem_* outputs with chipselect=1, and it is accepted on that edge.
  - The non-granted master sees waitrequest=1 and must hold its command stable (Avalon rule).
  - With no grant, mem_chipselect=0 and mem_write=0.
- Zero-bubble: back-to-back accepted transfers are allowed every cycle, alternating between masters under contention.
- Read return:
  - An accepted read sets rd_pend=1 and rd_id=N, both registered.
  - On the next cycle mN_readdatavalid = rd_pend & (rd_id==N).
  - mN_readdata = mem_readdata for both masters (unqualified data bus).
  - Read latency is exactly 1 and there is at most one read outstanding. No read-return stall exists, so a new read may be accepted in the same cycle the previous data returns.
- Lock state (IDLE / LOCKED):
  - IDLE -> LOCKED on acceptance of a transfer with mN_lock=1; owner=N.
  - LOCKED -> IDLE on an accepted owner transfer with lock=0. That transfer completes normally.
  - LOCKED -> IDLE when the owner has not requested for LOCK_TIMEOUT consecutive cycles: lock_timeout_err pulses for 1 cycle and rr_last=owner.
  - The idle counter clears on any owner request and saturates; it has no wrap.
- Round-robin update: rr_last updates to N on every accepted transfer.
- Reset:
  - State: rd_pend=0, lock IDLE, idle counter 0, rr_last=1 (so m0 wins the first contention).
  - Outputs during the reset cycle: both waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, lock_timeout_err=0.
  - A reset asserted mid-lock or with a read pending drops both; no readdatavalid is issued afterward for that read.
- Same-address same-cycle collisions with the other RAM port (mixed-port read-during-write) are not detected here; software ownership bits guard them.

Decomposition:
- Shared package desc_mem_pkg:
  - Constants: DESC_ADDR_W=11, DESC_DATA_W=32, DESC_BE_W=4.
  - Enum lock_state_t {LK_IDLE, LK_LOCKED}.
  - Master-id type (1 bit).
- No sub-module. The grant logic is small enough to stay inline.

Test Plan:
- Single master: m0 reads 0x010 with the RAM preloaded 0xA5A5_0001 -> m0_waitrequest=0 the same cycle; mem_address=0x010, chipselect=1; next cycle m0_readdatavalid=1, m0_readdata=0xA5A5_0001; m1_readdatavalid stays 0.
- Contention: m0 and m1 both write continuously from the cycle after reset -> accepts go m0, m1, m0, m1; exactly one waitrequest=0 per cycle; RAM contents match both writes.
- Locked RMW: m1 reads 0x020 with lock=1, then writes 0x020 with lock=0 and byteenable=0x1, while m0 requests every cycle -> m0 waitrequest=1 until the m1 write is accepted; m0 is granted the next cycle.
- Lock timeout with LOCK_TIMEOUT=64: m0 locks and then stops requesting while m1 requests -> m1 is blocked 64 cycles; lock_timeout_err pulses once; m1 is granted the following cycle.
- Reset mid-operation: reset asserted the cycle after an accepted m0 read while m1 holds a lock -> no readdatavalid afterward; after reset, simultaneous requests grant m0 first.
- Back-to-back reads: m0 reads 0x000 to 0x003 on consecutive cycles, uncontended -> four consecutive readdatavalid pulses, each lagging its address by 1 cycle, with data in order.
